regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised register file: DEPTH entries of WIDTH bits, one write port, two
//   independent registered read ports. Successor to the single-register block for
//   datapaths needing an addressable bank. Write-first bypass, optional hardwired-zero
//   entry 0, and a sequenced clear sweep with busy flag.
// PARAMETERS
//   WIDTH     8   data bits per entry (>=1)
//   DEPTH     8   number of entries (>=2, need not be a power of two)
//   ZERO_REG  0   1: entry 0 always reads 0, writes to it are dropped
//   localparam AW = $clog2(DEPTH)  address width
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   rst     in   1      synchronous, active-high reset
//   wen     in   1      write enable
//   waddr   in   AW     write address
//   wdata   in   WIDTH  write data
//   ren0    in   1      read enable, port 0
//   raddr0  in   AW     read address, port 0
//   rdata0  out  WIDTH  read data, port 0 (registered)
//   ren1    in   1      read enable, port 1
//   raddr1  in   AW     read address, port 1
//   rdata1  out  WIDTH  read data, port 1 (registered)
//   clr     in   1      start clear sweep (single-cycle pulse, level also accepted)
//   busy    out  1      clear sweep in progress
// BEHAVIOUR
//   Reset (rst=1 at posedge): all entries <= 0, rdata0/rdata1 <= 0, busy <= 0,
//     FSM <= IDLE, sweep counter <= 0. rst overrides every other input.
//   Write: wen=1 and waddr<DEPTH in IDLE -> entry[waddr] <= wdata at the edge.
//     waddr>=DEPTH: write dropped. ZERO_REG=1 and waddr=0: write dropped.
//   Read: latency 1. renN=1 at edge k -> rdataN valid after edge k. renN=0 -> rdataN
//     holds previous value. raddrN>=DEPTH -> 0. ZERO_REG=1 and raddrN=0 -> 0.
//   Bypass (write-first): accepted write (or sweep clear) to the same address being
//     read in the same cycle -> rdataN gets the new value (wdata, or 0 for sweep).
//     Dropped writes never bypass. Both ports may read the same address.
//   FSM states: IDLE, CLEAR.
//     IDLE: clr=1 -> CLEAR, cnt <= 0, busy <= 1. clr has priority over wen in the
//       same cycle; that write is dropped.
//     CLEAR: each cycle entry[cnt] <= 0, cnt <= cnt+1; on cnt==DEPTH-1 the entry is
//       cleared, -> IDLE, busy <= 0. Sweep takes exactly DEPTH cycles after clr edge.
//       wen ignored (writes dropped, no error flag). clr ignored (no restart).
//       Reads served normally: uncleared entries return old data, cleared return 0.
//   busy is registered: high on the edge after clr is sampled, low on the edge that
//     clears entry DEPTH-1. rst during CLEAR aborts sweep; all entries zeroed anyway.
//   No arithmetic beyond cnt (AW bits, never exceeds DEPTH-1, no wrap).
// TESTING
//   1) rst, then read all addrs on both ports -> rdata0=rdata1=0 every read.
//   2) W=8,D=8: write 0xA5 @3, next cycle ren0 raddr0=3 -> rdata0=0xA5 one cycle later;
//      ren0=0 after -> rdata0 stays 0xA5.
//   3) Same cycle wen waddr=5 wdata=0x3C, ren0 raddr0=5, ren1 raddr1=5 -> both rdata=0x3C
//      after the edge (bypass).
//   4) ZERO_REG=1: write 0xFF @0, read @0 same and next cycle -> 0x00; D=6: write @7
//      dropped, read @7 -> 0.
//   5) Fill entries 0..7 with 0x11..0x88; pulse clr with wen @2=0x99 same cycle -> busy
//      high for 8 cycles; read @7 during cycle 3 of sweep -> 0x88; write @4 mid-sweep
//      dropped; after busy falls every entry reads 0, @2 never held 0x99.
//   6) Assert rst at sweep cycle 4 -> busy=0 next cycle, all entries 0, new write/read
//      @1 works immediately after reset deasserts.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one write port, two registered read
// ports, write-first bypass, optional hardwired-zero entry 0 and a sequenced clear sweep.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr starts a sweep
// CLEAR | zeroing entry cnt each cycle, writes and clr ignored, reads still served
module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             ren1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic             clr,
    output logic             busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    // One extra bit so the range check stays meaningful when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd_next0;
    logic [WIDTH-1:0] rd_next1;

    assign wr_ok = (state == IDLE) && !clr && wen &&
                   ({1'b0, waddr} < DEPTH_X) && !(ZERO_REG && (waddr == '0));

    // Write-first: an accepted write or the sweep clear wins over the stored value.
    always_comb begin
        rd_next0 = '0;
        if (({1'b0, raddr0} < DEPTH_X) && !(ZERO_REG && (raddr0 == '0))) begin
            if (wr_ok && (waddr == raddr0))
                rd_next0 = wdata;
            else if ((state == CLEAR) && (cnt == raddr0))
                rd_next0 = '0;
            else
                rd_next0 = mem[raddr0];
        end
    end

    always_comb begin
        rd_next1 = '0;
        if (({1'b0, raddr1} < DEPTH_X) && !(ZERO_REG && (raddr1 == '0))) begin
            if (wr_ok && (waddr == raddr1))
                rd_next1 = wdata;
            else if ((state == CLEAR) && (cnt == raddr1))
                rd_next1 = '0;
            else
                rd_next1 = mem[raddr1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ren0) rdata0 <= rd_next0;
            if (ren1) rdata1 <= rd_next1;
            if (wr_ok) mem[waddr] <= wdata;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a plain 8x8 instance and a ZERO_REG 8x6 instance, checked
// through a queue of expected outputs pushed with each cycle's stimulus.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m_wen, m_ren0, m_ren1, m_clr, m_busy;
    logic [2:0] m_waddr, m_raddr0, m_raddr1;
    logic [7:0] m_wdata, m_rdata0, m_rdata1;
    logic       z_wen, z_ren0, z_ren1, z_clr, z_busy;
    logic [2:0] z_waddr, z_raddr0, z_raddr1;
    logic [7:0] z_wdata, z_rdata0, z_rdata1;

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) u_main (
        .clk(clk), .rst(rst), .wen(m_wen), .waddr(m_waddr), .wdata(m_wdata),
        .ren0(m_ren0), .raddr0(m_raddr0), .rdata0(m_rdata0),
        .ren1(m_ren1), .raddr1(m_raddr1), .rdata1(m_rdata1),
        .clr(m_clr), .busy(m_busy)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst(rst), .wen(z_wen), .waddr(z_waddr), .wdata(z_wdata),
        .ren0(z_ren0), .raddr0(z_raddr0), .rdata0(z_rdata0),
        .ren1(z_ren1), .raddr1(z_raddr1), .rdata1(z_rdata1),
        .clr(z_clr), .busy(z_busy)
    );

    typedef struct {
        int         port;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // port ids: 0 main rdata0, 1 main rdata1, 2 main busy, 3 zero rdata0, 4 zero rdata1, 5 zero busy
    function automatic logic [7:0] obs_of(input int p);
        case (p)
            0:       return m_rdata0;
            1:       return m_rdata1;
            2:       return {7'd0, m_busy};
            3:       return z_rdata0;
            4:       return z_rdata1;
            5:       return {7'd0, z_busy};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(input int p, input logic [7:0] v, input string n);
        exp_t e;
        e.port = p;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic idle_all();
        rst = 1'b0;
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_clr = 1'b0;
        m_ren0 = 1'b0; m_raddr0 = '0; m_ren1 = 1'b0; m_raddr1 = '0;
        z_wen = 1'b0; z_waddr = '0; z_wdata = '0; z_clr = 1'b0;
        z_ren0 = 1'b0; z_raddr0 = '0; z_ren1 = 1'b0; z_raddr1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 10; k++) begin
            idle_all();
            if (k < 2) begin
                rst = 1'b1;
                m_wen = 1'b1; m_waddr = 3'd1; m_wdata = 8'hEE;
                if (k == 1) begin
                    push(0, 8'h00, "reset_rdata0"); push(1, 8'h00, "reset_rdata1");
                    push(2, 8'h00, "reset_busy");   push(5, 8'h00, "reset_zbusy");
                end
            end else begin
                m_ren0 = 1'b1; m_raddr0 = 3'(k - 2);
                m_ren1 = 1'b1; m_raddr1 = 3'(9 - k);
                z_ren0 = 1'b1; z_raddr0 = 3'(k - 2);
                z_ren1 = 1'b1; z_raddr1 = 3'(9 - k);
                push(0, 8'h00, "reset_read_p0");  push(1, 8'h00, "reset_read_p1");
                push(3, 8'h00, "reset_zread_p0"); push(4, 8'h00, "reset_zread_p1");
            end
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 4; k++) begin
            idle_all();
            case (k)
                0: begin m_wen = 1'b1; m_waddr = 3'd3; m_wdata = 8'hA5; end
                1: begin
                    m_ren0 = 1'b1; m_raddr0 = 3'd3; push(0, 8'hA5, "read_a5_p0");
                    m_ren1 = 1'b1; m_raddr1 = 3'd3; push(1, 8'hA5, "read_a5_p1");
                    m_wen = 1'b1; m_waddr = 3'd6; m_wdata = 8'h5A;
                end
                2: begin
                    m_raddr0 = 3'd6; push(0, 8'hA5, "hold_p0");
                    m_ren1 = 1'b1; m_raddr1 = 3'd6; push(1, 8'h5A, "read_5a_p1");
                end
                default: begin
                    m_raddr1 = 3'd3; push(1, 8'h5A, "hold_p1");
                    m_ren0 = 1'b1; m_raddr0 = 3'd7; push(0, 8'h00, "read_unwritten");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            case (k)
                0: begin
                    m_wen = 1'b1; m_waddr = 3'd5; m_wdata = 8'h3C;
                    m_ren0 = 1'b1; m_raddr0 = 3'd5; push(0, 8'h3C, "bypass_p0");
                    m_ren1 = 1'b1; m_raddr1 = 3'd5; push(1, 8'h3C, "bypass_p1");
                end
                1: begin
                    m_wen = 1'b1; m_waddr = 3'd5; m_wdata = 8'hC3;
                    m_ren0 = 1'b1; m_raddr0 = 3'd5; push(0, 8'hC3, "bypass_overwrite");
                    m_ren1 = 1'b1; m_raddr1 = 3'd3; push(1, 8'hA5, "no_bypass_other");
                end
                default: begin
                    m_ren1 = 1'b1; m_raddr1 = 3'd5; push(1, 8'hC3, "bypass_stored");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 6; k++) begin
            idle_all();
            case (k)
                0: begin z_wen = 1'b1; z_waddr = 3'd1; z_wdata = 8'h77; end
                1: begin
                    z_wen = 1'b1; z_waddr = 3'd0; z_wdata = 8'hFF;
                    z_ren0 = 1'b1; z_raddr0 = 3'd0; push(3, 8'h00, "zero_same_cycle");
                    z_ren1 = 1'b1; z_raddr1 = 3'd1; push(4, 8'h77, "zero_inst_read1");
                end
                2: begin
                    z_ren0 = 1'b1; z_raddr0 = 3'd0; push(3, 8'h00, "zero_next_cycle");
                    z_wen = 1'b1; z_waddr = 3'd5; z_wdata = 8'h5A;
                    z_ren1 = 1'b1; z_raddr1 = 3'd5; push(4, 8'h5A, "bypass_last_entry");
                end
                3: begin
                    z_wen = 1'b1; z_waddr = 3'd7; z_wdata = 8'hEE;
                    z_ren1 = 1'b1; z_raddr1 = 3'd7; push(4, 8'h00, "oob_no_bypass");
                    z_ren0 = 1'b1; z_raddr0 = 3'd1; push(3, 8'h77, "zero_inst_read1b");
                end
                4: begin
                    z_ren1 = 1'b1; z_raddr1 = 3'd7; push(4, 8'h00, "oob_read7");
                    z_wen = 1'b1; z_waddr = 3'd6; z_wdata = 8'h11;
                    z_ren0 = 1'b1; z_raddr0 = 3'd6; push(3, 8'h00, "oob_read6");
                end
                default: begin
                    z_ren0 = 1'b1; z_raddr0 = 3'd5; push(3, 8'h5A, "last_entry_stored");
                    z_ren1 = 1'b1; z_raddr1 = 3'd0; push(4, 8'h00, "zero_stored");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 8; k++) begin
            idle_all();
            m_wen = 1'b1; m_waddr = 3'(k); m_wdata = 8'((k + 1) * 17);
            tick();
        end
        // k 0: clr edge, k 1..8: entry k-1 cleared, k 10..17: final readback
        for (int k = 0; k < 18; k++) begin
            idle_all();
            if (k < 10) push(2, (k < 8) ? 8'h01 : 8'h00, "sweep_busy");
            case (k)
                0: begin m_clr = 1'b1; m_wen = 1'b1; m_waddr = 3'd2; m_wdata = 8'h99; end
                1: begin m_ren0 = 1'b1; m_raddr0 = 3'd2; push(0, 8'h33, "clr_drops_write"); end
                2: begin
                    m_ren0 = 1'b1; m_raddr0 = 3'd0; push(0, 8'h00, "swept_entry0");
                    m_wen = 1'b1; m_waddr = 3'd4; m_wdata = 8'hDD;
                end
                3: begin
                    m_ren0 = 1'b1; m_raddr0 = 3'd7; push(0, 8'h88, "unswept_entry7");
                    m_ren1 = 1'b1; m_raddr1 = 3'd4; push(1, 8'h55, "sweep_drops_write");
                end
                4: begin m_ren0 = 1'b1; m_raddr0 = 3'd3; push(0, 8'h00, "sweep_bypass"); end
                5: m_clr = 1'b1;
                6: begin m_ren1 = 1'b1; m_raddr1 = 3'd7; push(1, 8'h88, "unswept_entry7b"); end
                8: begin m_ren0 = 1'b1; m_raddr0 = 3'd7; push(0, 8'h00, "sweep_last_bypass"); end
                default: begin
                    if (k >= 10) begin
                        m_ren0 = 1'b1; m_raddr0 = 3'(k - 10);
                        m_ren1 = 1'b1; m_raddr1 = 3'(17 - k);
                        push(0, 8'h00, "after_sweep_p0");
                        push(1, 8'h00, "after_sweep_p1");
                    end
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_rst_sweep();
        exp_t e;
        logic [7:0] got;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            m_wen = 1'b1;
            m_waddr = (k == 0) ? 3'd1 : (k == 1) ? 3'd6 : 3'd7;
            m_wdata = (k == 0) ? 8'h11 : (k == 1) ? 8'h66 : 8'h77;
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            idle_all();
            push(2, (k < 4) ? 8'h01 : 8'h00, "abort_busy");
            case (k)
                0: m_clr = 1'b1;
                3: begin m_ren0 = 1'b1; m_raddr0 = 3'd6; push(0, 8'h66, "pre_abort_read"); end
                4: begin
                    rst = 1'b1;
                    m_ren0 = 1'b1; m_raddr0 = 3'd7; push(0, 8'h00, "abort_rdata0");
                end
                5: begin
                    m_wen = 1'b1; m_waddr = 3'd1; m_wdata = 8'h42;
                    m_ren0 = 1'b1; m_raddr0 = 3'd1; push(0, 8'h42, "post_abort_bypass");
                    m_ren1 = 1'b1; m_raddr1 = 3'd6; push(1, 8'h00, "abort_zeroed6");
                end
                6: begin
                    m_ren0 = 1'b1; m_raddr0 = 3'd7; push(0, 8'h00, "abort_zeroed7");
                    m_ren1 = 1'b1; m_raddr1 = 3'd1; push(1, 8'h42, "post_abort_read");
                end
                default: ;
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs_of(e.port);
                tests_run++;
                if (got !== e.val) begin
                    tests_failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
                end
            end
        end
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_rst_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
